// File: rtl/debug_bridge_param_if.sv
// Byte-stream, program-memory, data-memory and core-control signals of debug_bridge_param.
// The master modport is the bridge side; the slave modport is the UART/core/memory side.
interface debug_bridge_param_if #(
    parameter int BYTE_WIDTH      = 8,
    parameter int WORD_WIDTH      = 32,
    parameter int PROG_ADDR_WIDTH = 11,
    parameter int DATA_ADDR_WIDTH = 10
);
    logic                       i_rx_done;
    logic [BYTE_WIDTH-1:0]      i_data_rx;
    logic                       i_tx_done;
    logic                       o_tx_start;
    logic [BYTE_WIDTH-1:0]      o_data_tx;
    logic                       o_write_mem_programa;
    logic [PROG_ADDR_WIDTH-1:0] o_addr_mem_programa;
    logic [WORD_WIDTH-1:0]      o_dato_mem_programa;
    logic [DATA_ADDR_WIDTH-1:0] o_addr_mem_datos;
    logic [WORD_WIDTH-1:0]      i_dato_mem_datos;
    logic                       i_bit_sucio;
    logic                       o_soft_reset;
    logic                       i_soft_reset_ack;
    logic                       o_modo_ejecucion;
    logic                       o_step;
    logic [WORD_WIDTH-1:0]      i_pc;
    logic                       i_halted;

    modport master (
        input  i_rx_done, i_data_rx, i_tx_done, i_dato_mem_datos, i_bit_sucio,
               i_soft_reset_ack, i_pc, i_halted,
        output o_tx_start, o_data_tx, o_write_mem_programa, o_addr_mem_programa,
               o_dato_mem_programa, o_addr_mem_datos, o_soft_reset, o_modo_ejecucion, o_step
    );

    modport slave (
        output i_rx_done, i_data_rx, i_tx_done, i_dato_mem_datos, i_bit_sucio,
               i_soft_reset_ack, i_pc, i_halted,
        input  o_tx_start, o_data_tx, o_write_mem_programa, o_addr_mem_programa,
               o_dato_mem_programa, o_addr_mem_datos, o_soft_reset, o_modo_ejecucion, o_step
    );
endinterface

// File: rtl/debug_bridge_param.sv
// UART debug bridge: program load, run/step, memory soft reset and dirty-word dump.
// Optional inter-byte LOAD timeout enabled by defining DEBUG_BRIDGE_TIMEOUT_EN.
module debug_bridge_param #(
    parameter int BYTE_WIDTH      = 8,
    parameter int WORD_WIDTH      = 32,
    parameter int PROG_ADDR_WIDTH = 11,
    parameter int DATA_ADDR_WIDTH = 10,
    parameter int OPCODE_WIDTH    = 6,
    parameter int HALT_OPCODE     = 0,
    parameter int TIMEOUT_CYCLES  = 10_000_000
) (
    input logic                  i_clock,
    input logic                  i_reset,
    debug_bridge_param_if.master bus
);
    localparam int WORD_BYTES  = WORD_WIDTH / BYTE_WIDTH;
    localparam int ADDR_BYTES  = (DATA_ADDR_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int ADDR_PAD_W  = ADDR_BYTES * BYTE_WIDTH;
    localparam int FRAME_BYTES = 1 + ADDR_BYTES + WORD_BYTES;
    localparam int FRAME_W     = FRAME_BYTES * BYTE_WIDTH;
    localparam int CNT_W       = $clog2(FRAME_BYTES + 1);
    localparam int BC_W        = $clog2(WORD_BYTES + 1);

    localparam logic [BYTE_WIDTH-1:0]   CMD_LOAD  = BYTE_WIDTH'(8'h01);
    localparam logic [BYTE_WIDTH-1:0]   CMD_RUN   = BYTE_WIDTH'(8'h02);
    localparam logic [BYTE_WIDTH-1:0]   CMD_STEP  = BYTE_WIDTH'(8'h03);
    localparam logic [BYTE_WIDTH-1:0]   CMD_SRST  = BYTE_WIDTH'(8'h04);
    localparam logic [BYTE_WIDTH-1:0]   RSP_OK    = BYTE_WIDTH'(8'hA5);
    localparam logic [BYTE_WIDTH-1:0]   RSP_ERR   = BYTE_WIDTH'(8'hEE);
    localparam logic [BYTE_WIDTH-1:0]   DUMP_TAG  = BYTE_WIDTH'(8'h01);
    localparam logic [BYTE_WIDTH-1:0]   DUMP_END  = BYTE_WIDTH'(8'h00);
    localparam logic [OPCODE_WIDTH-1:0] HALT_OP   = OPCODE_WIDTH'(HALT_OPCODE);
    localparam logic [BC_W-1:0]         LAST_BYTE = BC_W'(WORD_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_WR,
        S_RUN,
        S_STEP,
        S_SRST,
        S_DUMP_START,
        S_DUMP_ADDR,
        S_DUMP_CHK,
        S_DUMP_NEXT,
        S_SEND
    } state_t;

    state_t                     state, state_n;
    state_t                     ret, ret_n;
    logic [FRAME_W-1:0]         frame, frame_n;
    logic [CNT_W-1:0]           cnt, cnt_n;
    logic                       tx_busy, tx_busy_n;
    logic                       tx_start, tx_start_n;
    logic [BYTE_WIDTH-1:0]      data_tx, data_tx_n;
    logic [WORD_WIDTH-1:0]      word_buf, word_buf_n;
    logic [BC_W-1:0]            byte_cnt, byte_cnt_n;
    logic                       write_prog, write_prog_n;
    logic [PROG_ADDR_WIDTH-1:0] addr_prog, addr_prog_n;
    logic [WORD_WIDTH-1:0]      dato_prog, dato_prog_n;
    logic [DATA_ADDR_WIDTH-1:0] addr_datos, addr_datos_n;
    logic                       soft_reset, soft_reset_n;
    logic                       modo, modo_n;
    logic                       step, step_n;

    logic                       send_byte;
    logic [BYTE_WIDTH-1:0]      send_val;
    logic [WORD_WIDTH-1:0]      word_shift;
    logic [ADDR_PAD_W-1:0]      addr_pad;

    assign word_shift = (word_buf << BYTE_WIDTH) | WORD_WIDTH'(bus.i_data_rx);
    assign addr_pad   = ADDR_PAD_W'(addr_datos);

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt, to_cnt_n;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_n      = state;
        ret_n        = ret;
        frame_n      = frame;
        cnt_n        = cnt;
        tx_busy_n    = tx_busy & ~bus.i_tx_done;
        tx_start_n   = 1'b0;
        data_tx_n    = data_tx;
        word_buf_n   = word_buf;
        byte_cnt_n   = byte_cnt;
        write_prog_n = 1'b0;
        addr_prog_n  = addr_prog;
        dato_prog_n  = dato_prog;
        addr_datos_n = addr_datos;
        soft_reset_n = soft_reset;
        modo_n       = modo;
        step_n       = 1'b0;
        send_byte    = 1'b0;
        send_val     = '0;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        to_cnt_n     = to_cnt;
`endif

        case (state)
            S_IDLE: begin
                if (bus.i_rx_done) begin
                    case (bus.i_data_rx)
                        CMD_LOAD: begin
                            state_n     = S_LOAD;
                            addr_prog_n = '0;
                            byte_cnt_n  = '0;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
                            to_cnt_n    = '0;
`endif
                        end
                        CMD_RUN: begin
                            state_n = S_RUN;
                            modo_n  = 1'b1;
                        end
                        CMD_STEP: begin
                            state_n = S_STEP;
                            step_n  = 1'b1;
                        end
                        CMD_SRST: begin
                            state_n      = S_SRST;
                            soft_reset_n = 1'b1;
                        end
                        default: begin
                            send_byte = 1'b1;
                            send_val  = RSP_ERR;
                        end
                    endcase
                end
            end

            S_LOAD: begin
                if (bus.i_rx_done) begin
                    word_buf_n = word_shift;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
                    to_cnt_n   = '0;
`endif
                    if (byte_cnt == LAST_BYTE) begin
                        byte_cnt_n   = '0;
                        write_prog_n = 1'b1;
                        dato_prog_n  = word_shift;
                        state_n      = S_LOAD_WR;
                    end else begin
                        byte_cnt_n = byte_cnt + 1'b1;
                    end
                end
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    send_byte = 1'b1;
                    send_val  = RSP_ERR;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
`endif
            end

            // Write strobe is high this cycle; decide whether the program continues.
            S_LOAD_WR: begin
                if (dato_prog[WORD_WIDTH-1 -: OPCODE_WIDTH] == HALT_OP) begin
                    addr_prog_n = addr_prog + 1'b1;
                    send_byte   = 1'b1;
                    send_val    = RSP_OK;
                end else if (&addr_prog) begin
                    send_byte = 1'b1;
                    send_val  = RSP_ERR;
                end else begin
                    addr_prog_n = addr_prog + 1'b1;
                    state_n     = S_LOAD;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
                    to_cnt_n    = '0;
`endif
                end
            end

            S_RUN: begin
                if (bus.i_halted) begin
                    modo_n  = 1'b0;
                    state_n = S_DUMP_START;
                end
            end

            S_STEP: state_n = S_DUMP_START;

            S_SRST: begin
                if (bus.i_soft_reset_ack) begin
                    soft_reset_n = 1'b0;
                    send_byte    = 1'b1;
                    send_val     = RSP_OK;
                end
            end

            // PC is captured here, one cycle after a step pulse has been taken by the core.
            S_DUMP_START: begin
                frame_n      = {bus.i_pc, {(FRAME_W - WORD_WIDTH){1'b0}}};
                cnt_n        = CNT_W'(WORD_BYTES);
                ret_n        = S_DUMP_ADDR;
                addr_datos_n = '0;
                state_n      = S_SEND;
            end

            S_DUMP_ADDR: state_n = S_DUMP_CHK;

            S_DUMP_CHK: begin
                if (bus.i_bit_sucio) begin
                    frame_n = {DUMP_TAG, addr_pad, bus.i_dato_mem_datos};
                    cnt_n   = CNT_W'(FRAME_BYTES);
                    ret_n   = S_DUMP_NEXT;
                    state_n = S_SEND;
                end else begin
                    state_n = S_DUMP_NEXT;
                end
            end

            S_DUMP_NEXT: begin
                if (&addr_datos) begin
                    send_byte = 1'b1;
                    send_val  = DUMP_END;
                end else begin
                    addr_datos_n = addr_datos + 1'b1;
                    state_n      = S_DUMP_ADDR;
                end
            end

            // Shifts the frame out MSB byte first, one byte per transmitter release.
            S_SEND: begin
                if (cnt == '0) begin
                    state_n = ret;
                end else if (!tx_busy) begin
                    tx_start_n = 1'b1;
                    tx_busy_n  = 1'b1;
                    data_tx_n  = frame[FRAME_W-1 -: BYTE_WIDTH];
                    frame_n    = frame << BYTE_WIDTH;
                    cnt_n      = cnt - 1'b1;
                end
            end

            default: state_n = S_IDLE;
        endcase

        if (send_byte) begin
            frame_n = {send_val, {(FRAME_W - BYTE_WIDTH){1'b0}}};
            cnt_n   = CNT_W'(1);
            ret_n   = S_IDLE;
            state_n = S_SEND;
        end
    end

    // NOTE: state is updated only with non-blocking assignments; reset is synchronous, active-low.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state      <= S_IDLE;
            ret        <= S_IDLE;
            frame      <= '0;
            cnt        <= '0;
            tx_busy    <= 1'b0;
            tx_start   <= 1'b0;
            data_tx    <= '0;
            word_buf   <= '0;
            byte_cnt   <= '0;
            write_prog <= 1'b0;
            addr_prog  <= '0;
            dato_prog  <= '0;
            addr_datos <= '0;
            soft_reset <= 1'b0;
            modo       <= 1'b0;
            step       <= 1'b0;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
            to_cnt     <= '0;
`endif
        end else begin
            state      <= state_n;
            ret        <= ret_n;
            frame      <= frame_n;
            cnt        <= cnt_n;
            tx_busy    <= tx_busy_n;
            tx_start   <= tx_start_n;
            data_tx    <= data_tx_n;
            word_buf   <= word_buf_n;
            byte_cnt   <= byte_cnt_n;
            write_prog <= write_prog_n;
            addr_prog  <= addr_prog_n;
            dato_prog  <= dato_prog_n;
            addr_datos <= addr_datos_n;
            soft_reset <= soft_reset_n;
            modo       <= modo_n;
            step       <= step_n;
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
            to_cnt     <= to_cnt_n;
`endif
        end
    end

    assign bus.o_tx_start           = tx_start;
    assign bus.o_data_tx            = data_tx;
    assign bus.o_write_mem_programa = write_prog;
    assign bus.o_addr_mem_programa  = addr_prog;
    assign bus.o_dato_mem_programa  = dato_prog;
    assign bus.o_addr_mem_datos     = addr_datos;
    assign bus.o_soft_reset         = soft_reset;
    assign bus.o_modo_ejecucion     = modo;
    assign bus.o_step               = step;

endmodule

// File: tb/tb_debug_bridge_param.sv
// Directed bench for debug_bridge_param with a 4-word program memory and TIMEOUT_CYCLES=100.
// Models the UART transmitter, a dirty-tracking data memory and records program writes.
module tb_debug_bridge_param;
    localparam int PAW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    debug_bridge_param_if #(.PROG_ADDR_WIDTH(PAW)) bus ();

    debug_bridge_param #(
        .PROG_ADDR_WIDTH(PAW),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .i_clock(clk),
        .i_reset(rst_n),
        .bus    (bus.master)
    );

    int checks = 0;
    int failures = 0;
    int dirty_mode = 0;
    logic [7:0]        tx_q[$];
    logic [PAW+31:0]   wr_q[$];

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [9:0] a);
        return (dirty_mode == 0 && a == 10'd3) ? 32'h1234_5678 : {16'hC0DE, 6'b0, a};
    endfunction

    function automatic logic dirty_at(input logic [9:0] a);
        return (dirty_mode == 0) ? (a == 10'd3) : (a == 10'd0 || a == 10'd1023);
    endfunction

    // Registered read port: one cycle of latency from address to data.
    always @(posedge clk) begin
        bus.i_dato_mem_datos <= word_at(bus.o_addr_mem_datos);
        bus.i_bit_sucio      <= dirty_at(bus.o_addr_mem_datos);
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) tx_q.push_back(bus.o_data_tx);
            if (bus.o_write_mem_programa)
                wr_q.push_back({bus.o_addr_mem_programa, bus.o_dato_mem_programa});
        end
    end

    initial begin
        bus.i_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.o_tx_start) begin
                repeat (2) @(posedge clk);
                #1 bus.i_tx_done = 1'b1;
                @(posedge clk);
                #1 bus.i_tx_done = 1'b0;
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.i_data_rx = b;
        bus.i_rx_done = 1'b1;
        tick();
        bus.i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) begin
            send_byte(w[8*i +: 8]);
            tick();
        end
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 20000) begin
            tick();
            k++;
        end
        tick(20);
    endtask

    task automatic check_tx(input string tag, input int n, input logic [159:0] exp_bytes);
        logic [63:0] got;
        check({tag, "_len"}, 64'(tx_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < tx_q.size()) ? 64'(tx_q[i]) : '1;
            check($sformatf("%s_b%0d", tag, i), got, 64'(exp_bytes[8*(n-1-i) +: 8]));
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.o_tx_start, bus.o_data_tx, bus.o_write_mem_programa,
                    bus.o_addr_mem_programa, bus.o_dato_mem_programa, bus.o_addr_mem_datos,
                    bus.o_soft_reset, bus.o_modo_ejecucion, bus.o_step});
    endfunction

    task automatic count_high_srst(output int hi);
        hi = 0;
        for (int k = 0; k < 60; k++) begin
            if (bus.o_soft_reset) begin
                hi++;
                if (hi == 5) bus.i_soft_reset_ack = 1'b1;
            end else if (hi > 0) begin
                break;
            end
            tick();
        end
    endtask

    task automatic count_high_modo(input int halt_after, output int hi);
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            if (bus.o_modo_ejecucion) begin
                hi++;
                if (hi == halt_after) bus.i_halted = 1'b1;
            end else if (hi > 0) begin
                break;
            end
            tick();
        end
    endtask

    initial begin
        int hi;
        int n0;
        int lat;
        bus.i_rx_done        = 1'b0;
        bus.i_data_rx        = '0;
        bus.i_soft_reset_ack = 1'b0;
        bus.i_pc             = '0;
        bus.i_halted         = 1'b0;

        tick(3);
        check("reset_outputs", outs(), 64'd0);
        rst_n = 1'b1;
        tick(2);

        // LOAD of one instruction followed by a HALT word
        tx_q.delete(); wr_q.delete();
        send_byte(8'h01); tick();
        send_word(32'h2001_0005);
        send_word(32'h0000_0000);
        wait_tx(1);
        check("load_nwrites", 64'(wr_q.size()), 64'd2);
        check("load_w0", 64'(wr_q[0]), 64'({2'd0, 32'h2001_0005}));
        check("load_w1", 64'(wr_q[1]), 64'({2'd1, 32'h0000_0000}));
        check_tx("load_ack", 1, 160'hA5);

        // SRST with ack after five cycles
        tx_q.delete();
        send_byte(8'h04);
        count_high_srst(hi);
        bus.i_soft_reset_ack = 1'b0;
        check("srst_cycles", 64'(hi), 64'd5);
        wait_tx(1);
        check_tx("srst_ack", 1, 160'hA5);

        // STEP, one dirty word at address 3
        dirty_mode = 0;
        bus.i_pc   = 32'h0000_0004;
        tx_q.delete();
        send_byte(8'h03);
        check("step_pulse_hi", 64'(bus.o_step), 64'd1);
        tick();
        check("step_pulse_lo", 64'(bus.o_step), 64'd0);
        wait_tx(12);
        check_tx("step_dump", 12, 160'h00000004_01_0003_12345678_00);

        // RUN, core halts after 20 cycles; first and last addresses dirty
        dirty_mode = 1;
        bus.i_pc   = 32'h0000_0100;
        tx_q.delete();
        send_byte(8'h02);
        count_high_modo(20, hi);
        check("run_cycles", 64'(hi), 64'd20);
        wait_tx(19);
        check_tx("run_dump", 19, 160'h00000100_01_0000_C0DE0000_01_03FF_C0DE03FF_00);

        // RUN with the core already halted
        tx_q.delete();
        send_byte(8'h02);
        count_high_modo(0, hi);
        check("run_halted_cycles", 64'(hi), 64'd1);
        wait_tx(19);
        check_tx("run_halted_dump", 19, 160'h00000100_01_0000_C0DE0000_01_03FF_C0DE03FF_00);
        bus.i_halted = 1'b0;

        // Unknown command
        tx_q.delete();
        send_byte(8'h7F);
        wait_tx(1);
        check_tx("bad_cmd", 1, 160'hEE);

        // Program memory fills without a HALT word
        tx_q.delete(); wr_q.delete();
        send_byte(8'h01); tick();
        for (int i = 0; i < 4; i++) send_word(32'h0400_0000 + 32'(i));
        wait_tx(1);
        check("full_nwrites", 64'(wr_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            check($sformatf("full_w%0d", i), 64'(wr_q[i]), 64'({i[1:0], 32'h0400_0000 + 32'(i)}));
        check_tx("full_err", 1, 160'hEE);

        // Reset in the middle of a dump
        dirty_mode = 0;
        tx_q.delete();
        send_byte(8'h03);
        for (int k = 0; k < 2000 && tx_q.size() < 2; k++) tick();
        rst_n = 1'b0;
        tick();
        check("rst_mid_outputs", outs(), 64'd0);
        tick(2);
        rst_n = 1'b1;
        n0 = tx_q.size();
        tick(60);
        check("rst_mid_no_tx", 64'(tx_q.size()), 64'(n0));
        check("rst_mid_idle", outs(), 64'd0);

        // SRST with ack already high
        bus.i_soft_reset_ack = 1'b1;
        tx_q.delete();
        send_byte(8'h04);
        count_high_srst(hi);
        bus.i_soft_reset_ack = 1'b0;
        check("srst_fast_cycles", 64'(hi), 64'd1);
        wait_tx(1);
        check_tx("srst_fast_ack", 1, 160'hA5);

        // LOAD stalls after two bytes of the first word
        tx_q.delete(); wr_q.delete();
        send_byte(8'h01); tick();
        send_byte(8'h00); tick();
        send_byte(8'h00);
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        lat = 0;
        while (tx_q.size() < 1 && lat < 1000) begin
            tick();
            lat++;
        end
        check("timeout_latency", 64'(lat >= 95 && lat <= 110), 64'd1);
        tick(20);
        check_tx("timeout_err", 1, 160'hEE);
        check("timeout_nwrites", 64'(wr_q.size()), 64'd0);
`else
        lat = 0;
        tick(300);
        check("no_timeout_tx", 64'(tx_q.size()), 64'(lat));
        send_byte(8'h00); tick();
        send_byte(8'h00);
        wait_tx(1);
        check_tx("late_word_ack", 1, 160'hA5);
        check("late_word_nwrites", 64'(wr_q.size()), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
